// File: rtl/pl_muldiv_unit_if.sv
//==============================================================================
// Module      : pl_muldiv_unit_if
// Description : EX-stage <-> multiply/divide unit connection: issue, HI/LO
//               move-to/move-from strobes, and HI/LO/status returns.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pl_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hilo_rd;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  // pipeline side: issues operations and MT writes, observes HI/LO and status
  modport master (
    output start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wr_data,
    input  hi, lo, busy, stall, done, div_by_zero
  );

  // unit side
  modport slave (
    input  start, op, rs_val, rt_val, hilo_rd, hi_we, lo_we, wr_data,
    output hi, lo, busy, stall, done, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/pl_muldiv_unit.sv
//==============================================================================
// Module      : pl_muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//               One bit per cycle on magnitudes, sign fix-up at the end.
//               Start to result is WIDTH+3 cycles; divide-by-zero finishes
//               after two cycles with HI/LO untouched.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pl_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input wire              clk,
  input wire              rst_n,
  pl_muldiv_unit_if.slave bus
);

  localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   opa;       // rs as issued
  logic [WIDTH-1:0]   opb;       // rt as issued; multiplicand/divisor magnitude after PREP
  logic [2*WIDTH-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // negate remainder
  logic [CW-1:0]      count;

  logic               div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign div_zero  = is_div && (opb == '0);
  // 0x80..0 negates to itself, which is the correct unsigned magnitude
  assign mag_a     = (is_signed && opa[WIDTH-1]) ? -opa : opa;
  assign mag_b     = (is_signed && opb[WIDTH-1]) ? -opb : opb;

  // shift-add: add multiplicand into the upper half when the next multiplier bit is set
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  // restoring division: bring in the next dividend bit and trial-subtract the divisor
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opb};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign prod_fix  = neg_q ? -acc : acc;
  assign quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PREP;
      PREP:    state_nxt = div_zero ? IDLE : RUN;
      RUN:     if (count == LAST_COUNT) state_nxt = FIX;
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    bus.busy  = (state != IDLE);
    bus.stall = (state != IDLE) && (bus.start || bus.hilo_rd);
  end

  // datapath, HI/LO and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      is_div          <= 1'b0;
      is_signed       <= 1'b0;
      opa             <= '0;
      opb             <= '0;
      acc             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      count           <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          // MT writes land here; a start in the same cycle later overwrites them
          if (bus.hi_we) bus.hi <= bus.wr_data;
          if (bus.lo_we) bus.lo <= bus.wr_data;
          if (bus.start) begin
            is_div    <= bus.op[1];
            is_signed <= ~bus.op[0];
            opa       <= bus.rs_val;
            opb       <= bus.rt_val;
          end
        end
        PREP: begin
          neg_q <= is_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
          neg_r <= is_signed && opa[WIDTH-1];
          count <= '0;
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, mag_a};
            opb <= mag_b;
          end else begin
            acc <= {{WIDTH{1'b0}}, mag_b};
            opb <= mag_a;
          end
          if (div_zero) begin
            bus.done        <= 1'b1;
            bus.div_by_zero <= 1'b1;
          end
        end
        RUN: begin
          count <= count + CW'(1);
          acc   <= is_div ? {div_rem, acc[WIDTH-2:0], div_ok}
                          : {mul_sum, acc[WIDTH-1:1]};
        end
        default: begin
          bus.done <= 1'b1;
          if (is_div) begin
            bus.hi <= rem_fix;
            bus.lo <= quo_fix;
          end else begin
            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
            bus.lo <= prod_fix[WIDTH-1:0];
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
